// File: rtl/branch_target_predictor_pkg.sv
// rtl/branch_target_predictor_pkg.sv - shared types and helpers for the branch target predictor
package branch_target_predictor_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Saturating increment toward strongly taken
    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
    endfunction

    // Saturating decrement toward strongly not taken
    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    endfunction

    // Word index into the table; callers size-cast the result to IDX_W bits
    function automatic logic [PC_W-1:0] pc_index(input logic [PC_W-1:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag is everything above the index; callers size-cast to the tag width
    function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_target_predictor_btb_storage.sv
// rtl/branch_target_predictor_btb_storage.sv - direct-mapped BTB arrays with lookup and training ports
module btb_storage
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             reset,
    // lookup port
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_hit,
    output ctr_t             lk_ctr,
    output logic [PC_W-1:0]  lk_target,
    // training port
    input  logic             tr_en,
    input  logic [IDX_W-1:0] tr_idx,
    input  logic [TAG_W-1:0] tr_tag,
    input  logic             tr_taken,
    input  logic [PC_W-1:0]  tr_target
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    logic               tr_hit;

    // Lookup reads the registered contents, so a same-cycle update is not visible yet
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_ctr    = ctr_q[lk_idx];
    assign lk_target = target_q[lk_idx];

    assign tr_hit    = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

    // Training: hits move the counter, taken misses allocate, not-taken misses are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (tr_en) begin
            if (tr_hit) begin
                if (tr_taken) begin
                    ctr_q[tr_idx]    <= ctr_inc(ctr_q[tr_idx]);
                    target_q[tr_idx] <= tr_target;
                end else begin
                    ctr_q[tr_idx] <= ctr_dec(ctr_q[tr_idx]);
                end
            end else if (tr_taken) begin
                valid_q[tr_idx]  <= 1'b1;
                tag_q[tr_idx]    <= tr_tag;
                target_q[tr_idx] <= tr_target;
                ctr_q[tr_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - next-PC generator with BTB prediction and EX-stage correction
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_current,
    output logic [PC_W-1:0] next_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic            flush,
    output logic [31:0]     mispredict_count
);

    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] tr_idx;
    logic [TAG_W-1:0] tr_tag;
    logic             lk_hit;
    ctr_t             lk_ctr;
    logic [PC_W-1:0]  lk_target;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  ex_pc_plus4;
    logic             resolve;
    logic             mispredict;

    assign lk_idx = IDX_W'(pc_index(pc_current, IDX_W));
    assign lk_tag = TAG_W'(pc_tag(pc_current, IDX_W));
    assign tr_idx = IDX_W'(pc_index(ex_pc, IDX_W));
    assign tr_tag = TAG_W'(pc_tag(ex_pc, IDX_W));

    btb_storage #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lk_idx    (lk_idx),
        .lk_tag    (lk_tag),
        .lk_hit    (lk_hit),
        .lk_ctr    (lk_ctr),
        .lk_target (lk_target),
        .tr_en     (resolve),
        .tr_idx    (tr_idx),
        .tr_tag    (tr_tag),
        .tr_taken  (ex_taken),
        .tr_target (ex_target)
    );

    // Adds wrap modulo 2^32
    assign pc_plus4    = pc_current + 32'd4;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    assign pred_taken  = lk_hit && lk_ctr[1];
    assign pred_target = lk_hit ? lk_target : pc_plus4;

    // A resolved branch is wrong if the direction differs or a taken target differs
    assign resolve    = ex_valid && ex_is_branch;
    assign mispredict = resolve && ((ex_pred_taken != ex_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));
    assign flush      = mispredict;

    // Correction from EX outranks the fetch-side prediction
    always_comb begin
        next_pc = pc_plus4;
        if (mispredict) begin
            next_pc = ex_taken ? ex_target : ex_pc_plus4;
        end else if (pred_taken) begin
            next_pc = lk_target;
        end
    end

    // Wrapping misprediction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count <= '0;
        end else if (mispredict) begin
            mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Next-PC generator directly upstream of the PC register; its next_pc output drives the PC register's PC_in.
- Looks up the current PC in a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and predicts either the branch target or PC+4.
- Trains on branch outcomes resolved in EX.
- On a misprediction it overrides the prediction with the corrected PC and raises flush for the IF/ID and ID/EX registers.

Parameters:
- ENTRIES, 16, number of BTB entries (power of two).
- IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pc_current  input  32  current PC (PC register's PC_out).
- next_pc  output  32  next PC, feeds the PC register's PC_in.
- pred_taken  output  1  prediction for pc_current; the pipeline carries it to EX.
- pred_target  output  32  predicted target; the pipeline carries it to EX.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  32  PC of the EX instruction.
- ex_taken  input  1  resolved branch direction.
- ex_target  input  32  resolved branch target.
- ex_pred_taken  input  1  prediction that was made for ex_pc.
- ex_pred_target  input  32  predicted target that was made for ex_pc.
- flush  output  1  misprediction; squash younger instructions.
- mispredict_count  output  32  wrapping count of mispredictions.

Behaviour:
- Reset (asynchronous, immediate): all valid bits 0, all counters 2'b01, mispredict_count 0.
  - Because of the above, after reset next_pc = pc_current+4, pred_taken = 0, flush = 0.
- Lookup is combinational, with zero latency from pc_current:
  - hit = valid[idx] and tag[idx] == pc tag.
  - pred_taken = hit and ctr[idx][1].
  - pred_target = target[idx] when hit, else pc_current+4.
- resolve = ex_valid and ex_is_branch.
- mispredict = resolve and (ex_pred_taken != ex_taken, or ex_taken and ex_pred_target != ex_target).
- next_pc priority:
  - mispredict: ex_taken ? ex_target : ex_pc+4.
  - else pred_taken: target[idx].
  - else pc_current+4.
- All PC adds are 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
- flush = mispredict, combinational in the same cycle.
- Training happens on the clock edge when resolve = 1, with a lookup of ex_pc in the table:
  - Hit, taken: ctr saturating increment (max 11); target <= ex_target.
  - Hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate or replace the entry: valid 1, tag, target <= ex_target, ctr 10.
  - Miss, not taken: no change.
  - ex_valid with a non-branch instruction: no change.
- mispredict_count increments on each cycle with mispredict = 1; wraps 0xFFFFFFFF -> 0.
- Same index read and written in one cycle: the lookup sees the pre-update contents; the update is visible from the next cycle.
- PC-register stalls are not visible to this block. Training proceeds regardless; the held PC simply re-looks up.
- Reset asserted mid-operation clears state at once, with no clock needed; deassertion takes effect from the next edge.

Decomposition:
- Shared package holds:
  - PC width 32.
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Saturating increment/decrement functions.
  - Index/tag extraction functions parameterised by IDX_W.
- One sub-module, btb_storage, holds the valid/tag/target/counter arrays with:
  - one asynchronous read port (lookup);
  - one read-modify-write port (training);
  - asynchronous clear.
- The top level holds the next_pc mux, the mispredict compare and the counter.

Test Plan:
- Reset, pc_current=0x40, no resolve -> next_pc=0x44, pred_taken=0, flush=0, mispredict_count=0.
- Resolve ex_pc=0x40 taken, ex_target=0x100, ex_pred_taken=0:
  - same cycle: next_pc=0x100, flush=1;
  - after the edge, pc_current=0x40 -> pred_taken=1, next_pc=0x100, mispredict_count=1.
- Then resolve 0x40 not taken, ex_pred_taken=1, ex_pred_target=0x100:
  - next_pc=0x44, flush=1;
  - ctr 10->01; the lookup of 0x40 then gives pred_taken=0.
- Aliasing: with 0x40 trained taken, resolve ex_pc=0x80 (same index 0) taken, target 0x200 -> entry replaced:
  - 0x40 lookup misses (next_pc=0x44);
  - 0x80 lookup gives next_pc=0x200.
- Saturation: resolve 0x40 taken and correctly predicted four times -> ctr=11, flush=0 each time, count unchanged; one not-taken -> ctr=10, still predicts taken.
- Assert reset between clock edges after training -> pred_taken=0 and mispredict_count=0 immediately, before the next clk edge.
